// File: rtl/rmt_tx_merge.sv
// Frame-granular round-robin merge of S_COUNT AXI-Stream returns into one registered egress.
// Optional header stamping on first beats when RMT_TX_STAMP_EN is defined.
module rmt_tx_merge #(
    parameter int DATA_WIDTH = 512,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int USER_WIDTH = 8,
    parameter int S_COUNT    = 2,
    parameter int ID_WIDTH   = 3
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [S_COUNT*DATA_WIDTH-1:0]  s_axis_tdata,
    input  logic [S_COUNT*KEEP_WIDTH-1:0]  s_axis_tkeep,
    input  logic [S_COUNT-1:0]             s_axis_tvalid,
    output logic [S_COUNT-1:0]             s_axis_tready,
    input  logic [S_COUNT-1:0]             s_axis_tlast,
    input  logic [S_COUNT*USER_WIDTH-1:0]  s_axis_tuser,
    output logic [DATA_WIDTH-1:0]          m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]          m_axis_tkeep,
    output logic                           m_axis_tvalid,
    input  logic                           m_axis_tready,
    output logic                           m_axis_tlast,
    output logic [USER_WIDTH-1:0]          m_axis_tuser,
    output logic [ID_WIDTH-1:0]            m_axis_tid,
    output logic [31:0]                    stat_frame_count
);

    typedef enum logic {IDLE, XFER} state_t;

    state_t                state_q, state_d;
    logic [ID_WIDTH-1:0]   grant_q, grant_d;
    logic [ID_WIDTH-1:0]   last_grant_q, last_grant_d;
    logic                  first_q, first_d;
    logic                  m_valid_q, m_valid_d;
    logic                  m_last_q, m_last_d;
    logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
    logic [KEEP_WIDTH-1:0] m_keep_q, m_keep_d;
    logic [USER_WIDTH-1:0] m_user_q, m_user_d;
    logic [ID_WIDTH-1:0]   m_tid_q, m_tid_d;
    logic [31:0]           cnt_q, cnt_d;

    logic                  any_valid;
    logic [ID_WIDTH-1:0]   pick;
    logic [ID_WIDTH-1:0]   cur_grant;
    logic                  active;
    logic                  can_load;
    logic                  sel_valid;
    logic                  sel_last;
    logic [DATA_WIDTH-1:0] sel_data;
    logic [KEEP_WIDTH-1:0] sel_keep;
    logic [USER_WIDTH-1:0] sel_user;
    logic                  accept;
    logic                  first_beat;
    logic [DATA_WIDTH-1:0] beat_data;

    // Round-robin pick: first valid port strictly after last_grant.
    always_comb begin
        pick      = last_grant_q;
        any_valid = 1'b0;
        for (int i = 1; i <= S_COUNT; i++) begin
            for (int j = 0; j < S_COUNT; j++) begin
                if (!any_valid && s_axis_tvalid[j] &&
                    ((int'(last_grant_q) + i) % S_COUNT) == j) begin
                    any_valid = 1'b1;
                    pick      = ID_WIDTH'(j);
                end
            end
        end
    end

    always_comb begin
        cur_grant = (state_q == XFER) ? grant_q : pick;
        active    = (state_q == XFER) || any_valid;
        can_load  = !m_valid_q || m_axis_tready;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        sel_keep  = '0;
        sel_user  = '0;
        s_axis_tready = '0;
        for (int j = 0; j < S_COUNT; j++) begin
            if (ID_WIDTH'(j) == cur_grant) begin
                sel_valid = s_axis_tvalid[j];
                sel_last  = s_axis_tlast[j];
                sel_data  = s_axis_tdata[j*DATA_WIDTH +: DATA_WIDTH];
                sel_keep  = s_axis_tkeep[j*KEEP_WIDTH +: KEEP_WIDTH];
                sel_user  = s_axis_tuser[j*USER_WIDTH +: USER_WIDTH];
                s_axis_tready[j] = active && can_load && !rst;
            end
        end
        accept     = active && can_load && sel_valid && !rst;
        first_beat = (state_q == IDLE) || first_q;
        beat_data  = sel_data;
`ifdef RMT_TX_STAMP_EN
        if (first_beat && sel_data[12*8 +: 16] == 16'h0008) begin
            beat_data[42*8 +: 16] = 16'hF0E1;
            beat_data[44*8 +: 16] = 16'(cur_grant) + 16'd1;
        end
`endif
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        first_d      = first_q;
        m_valid_d    = m_valid_q;
        m_last_d     = m_last_q;
        m_data_d     = m_data_q;
        m_keep_d     = m_keep_q;
        m_user_d     = m_user_q;
        m_tid_d      = m_tid_q;
        cnt_d        = cnt_q;

        unique case (state_q)
            IDLE: begin
                if (any_valid) begin
                    if (accept && sel_last) begin
                        last_grant_d = pick;
                    end else begin
                        state_d = XFER;
                        grant_d = pick;
                        first_d = !accept;
                    end
                end
            end
            XFER: begin
                if (accept) begin
                    first_d = 1'b0;
                    if (sel_last) begin
                        state_d      = IDLE;
                        last_grant_d = grant_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            m_valid_d = 1'b1;
            m_last_d  = sel_last;
            m_data_d  = beat_data;
            m_keep_d  = sel_keep;
            m_user_d  = sel_user;
            m_tid_d   = cur_grant;
        end else if (m_axis_tready) begin
            m_valid_d = 1'b0;
        end

        if (m_valid_q && m_axis_tready && m_last_q) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= ID_WIDTH'(S_COUNT - 1);
            first_q      <= 1'b0;
            m_valid_q    <= 1'b0;
            m_last_q     <= 1'b0;
            m_data_q     <= '0;
            m_keep_q     <= '0;
            m_user_q     <= '0;
            m_tid_q      <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            first_q      <= first_d;
            m_valid_q    <= m_valid_d;
            m_last_q     <= m_last_d;
            m_data_q     <= m_data_d;
            m_keep_q     <= m_keep_d;
            m_user_q     <= m_user_d;
            m_tid_q      <= m_tid_d;
            cnt_q        <= cnt_d;
        end
    end

    assign m_axis_tdata     = m_data_q;
    assign m_axis_tkeep     = m_keep_q;
    assign m_axis_tvalid    = m_valid_q;
    assign m_axis_tlast     = m_last_q;
    assign m_axis_tuser     = m_user_q;
    assign m_axis_tid       = m_tid_q;
    assign stat_frame_count = cnt_q;

endmodule

// File: tb/tb_rmt_tx_merge.sv
// Directed bench for rmt_tx_merge: arbitration, stalls, grant hold,
// stamping, counter wrap and mid-frame reset.
module tb_rmt_tx_merge;

    localparam int DW = 512;
    localparam int KW = 64;
    localparam int UW = 8;
    localparam int SC = 2;
    localparam int IW = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [SC*DW-1:0]  s_axis_tdata;
    logic [SC*KW-1:0]  s_axis_tkeep;
    logic [SC-1:0]     s_axis_tvalid;
    logic [SC-1:0]     s_axis_tready;
    logic [SC-1:0]     s_axis_tlast;
    logic [SC*UW-1:0]  s_axis_tuser;
    logic [DW-1:0]     m_axis_tdata;
    logic [KW-1:0]     m_axis_tkeep;
    logic              m_axis_tvalid;
    logic              m_axis_tready = 1'b1;
    logic              m_axis_tlast;
    logic [UW-1:0]     m_axis_tuser;
    logic [IW-1:0]     m_axis_tid;
    logic [31:0]       stat_frame_count;

    logic [DW-1:0] td [SC];
    logic [KW-1:0] tk [SC];
    logic [UW-1:0] tu [SC];
    logic          tv [SC];
    logic          tl [SC];

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [DW-1:0] mq_data [$];
    logic [KW-1:0] mq_keep [$];
    logic [UW-1:0] mq_user [$];
    logic          mq_last [$];
    int            mq_tid  [$];
    int            mq_cyc  [$];

    always #5 clk = ~clk;

    always_comb begin
        for (int p = 0; p < SC; p++) begin
            s_axis_tdata[p*DW +: DW] = td[p];
            s_axis_tkeep[p*KW +: KW] = tk[p];
            s_axis_tuser[p*UW +: UW] = tu[p];
            s_axis_tvalid[p]         = tv[p];
            s_axis_tlast[p]          = tl[p];
        end
    end

    rmt_tx_merge dut (
        .clk              (clk),
        .rst              (rst),
        .s_axis_tdata     (s_axis_tdata),
        .s_axis_tkeep     (s_axis_tkeep),
        .s_axis_tvalid    (s_axis_tvalid),
        .s_axis_tready    (s_axis_tready),
        .s_axis_tlast     (s_axis_tlast),
        .s_axis_tuser     (s_axis_tuser),
        .m_axis_tdata     (m_axis_tdata),
        .m_axis_tkeep     (m_axis_tkeep),
        .m_axis_tvalid    (m_axis_tvalid),
        .m_axis_tready    (m_axis_tready),
        .m_axis_tlast     (m_axis_tlast),
        .m_axis_tuser     (m_axis_tuser),
        .m_axis_tid       (m_axis_tid),
        .stat_frame_count (stat_frame_count)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst && m_axis_tvalid && m_axis_tready) begin
            mq_data.push_back(m_axis_tdata);
            mq_keep.push_back(m_axis_tkeep);
            mq_user.push_back(m_axis_tuser);
            mq_last.push_back(m_axis_tlast);
            mq_tid.push_back(int'(m_axis_tid));
            mq_cyc.push_back(cyc);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [DW-1:0] pat(input int p, input int beat);
        logic [DW-1:0] r;
        for (int w = 0; w < DW / 32; w++)
            r[w*32 +: 32] = 32'hA5A5_5A5A ^ 32'(p << 12) ^ 32'(beat << 4) ^ 32'(w);
        return r;
    endfunction

    function automatic logic [DW-1:0] beat_data(input int p, input int beat,
                                                input bit set_eth, input logic [15:0] eth);
        logic [DW-1:0] r;
        r = pat(p, beat);
        if (set_eth) r[12*8 +: 16] = eth;
        return r;
    endfunction

    function automatic logic [KW-1:0] beat_keep(input int b, input int n);
        return (b == n - 1) ? 64'h0000_FFFF_FFFF_FFFF : {KW{1'b1}};
    endfunction

    task automatic clear_mon();
        mq_data.delete(); mq_keep.delete(); mq_user.delete();
        mq_last.delete(); mq_tid.delete(); mq_cyc.delete();
    endtask

    task automatic drain();
        repeat (3) begin @(posedge clk); #1; end
    endtask

    task automatic drive_port(input int p, input int n, input int tag,
                              input int gap_at, input int gap_len,
                              input bit set_eth, input logic [15:0] eth);
        bit hs;
        int guard;
        for (int b = 0; b < n; b++) begin
            if (b == gap_at) begin
                tv[p] = 1'b0;
                repeat (gap_len) begin @(posedge clk); #1; end
            end
            td[p] = beat_data(p, tag + b, set_eth, eth);
            tk[p] = beat_keep(b, n);
            tu[p] = 8'(tag + b);
            tl[p] = (b == n - 1);
            tv[p] = 1'b1;
            hs = 1'b0;
            guard = 0;
            while (!hs && guard < 200) begin
                @(negedge clk);
                hs = s_axis_tready[p] && s_axis_tvalid[p];
                @(posedge clk); #1;
                guard++;
            end
            checks++;
            if (!hs) begin
                errors++;
                $display("FAIL handshake p%0d b%0d: tready=0 required=1 within 200 cycles", p, b);
            end
        end
        tv[p] = 1'b0;
        tl[p] = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int p = 0; p < SC; p++) begin
            td[p] = pat(p, 99); tk[p] = '1; tu[p] = 8'h5A; tv[p] = 1'b1; tl[p] = 1'b0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid_last: got %b/%b required 0/0", m_axis_tvalid, m_axis_tlast);
        end
        checks++;
        if (m_axis_tdata !== '0 || m_axis_tkeep !== '0 || m_axis_tuser !== '0) begin
            errors++;
            $display("FAIL reset_data: got keep=%h user=%h required 0", m_axis_tkeep, m_axis_tuser);
        end
        checks++;
        if (m_axis_tid !== 3'd0 || stat_frame_count !== 32'd0) begin
            errors++;
            $display("FAIL reset_tid_cnt: got %0d/%0d required 0/0", m_axis_tid, stat_frame_count);
        end
        checks++;
        if (s_axis_tready !== 2'b00) begin
            errors++;
            $display("FAIL reset_tready: got %b required 00", s_axis_tready);
        end
        for (int p = 0; p < SC; p++) tv[p] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_arbitration();
        clear_mon();
        m_axis_tready = 1'b1;
        fork
            drive_port(0, 3, 0, -1, 0, 1'b0, 16'h0);
            drive_port(1, 3, 0, -1, 0, 1'b0, 16'h0);
        join
        drain();
        checks++;
        if (mq_data.size() != 6) begin
            errors++;
            $display("FAIL arb_count: got %0d beats required 6", mq_data.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (mq_tid[i] != i / 3 || mq_data[i] !== pat(i / 3, i % 3) ||
                    mq_last[i] !== (i % 3 == 2) || mq_user[i] !== 8'(i % 3) ||
                    mq_keep[i] !== beat_keep(i % 3, 3)) begin
                    errors++;
                    $display("FAIL arb_beat%0d: got tid=%0d last=%b user=%h required tid=%0d last=%b user=%h",
                             i, mq_tid[i], mq_last[i], mq_user[i], i / 3, (i % 3 == 2), 8'(i % 3));
                end
                checks++;
                if (mq_cyc[i] != mq_cyc[0] + i) begin
                    errors++;
                    $display("FAIL arb_gap%0d: got cycle %0d required %0d", i, mq_cyc[i], mq_cyc[0] + i);
                end
            end
        end
        checks++;
        if (stat_frame_count !== 32'd2) begin
            errors++;
            $display("FAIL arb_frames: got %0d required 2", stat_frame_count);
        end
    endtask

    task automatic test_stall();
        logic          prev_stall;
        logic [DW-1:0] prev_data;
        clear_mon();
        prev_stall = 1'b0;
        prev_data  = '0;
        fork
            drive_port(1, 4, 16, -1, 0, 1'b0, 16'h0);
            begin
                m_axis_tready = 1'b1;
                @(posedge clk); #1 m_axis_tready = 1'b0;
                @(posedge clk); #1;
                @(posedge clk); #1 m_axis_tready = 1'b1;
            end
            for (int c = 0; c < 12; c++) begin
                @(negedge clk);
                if (prev_stall) begin
                    checks++;
                    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== prev_data) begin
                        errors++;
                        $display("FAIL stall_hold c%0d: got valid=%b data_lsw=%h required 1/%h",
                                 c, m_axis_tvalid, m_axis_tdata[31:0], prev_data[31:0]);
                    end
                end
                prev_stall = m_axis_tvalid && !m_axis_tready;
                prev_data  = m_axis_tdata;
            end
        join
        drain();
        checks++;
        if (mq_data.size() != 4) begin
            errors++;
            $display("FAIL stall_count: got %0d beats required 4", mq_data.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (mq_tid[i] != 1 || mq_data[i] !== pat(1, 16 + i) || mq_last[i] !== (i == 3)) begin
                    errors++;
                    $display("FAIL stall_beat%0d: got tid=%0d lsw=%h required tid=1 lsw=%h",
                             i, mq_tid[i], mq_data[i][31:0], pat(1, 16 + i) & 32'hFFFF_FFFF);
                end
            end
        end
    endtask

    task automatic test_hold_grant();
        int etid [6];
        int ebeat [6];
        etid  = '{0, 0, 0, 0, 1, 1};
        ebeat = '{0, 1, 2, 3, 8, 9};
        clear_mon();
        m_axis_tready = 1'b1;
        fork
            drive_port(0, 4, 0, 2, 2, 1'b0, 16'h0);
            drive_port(1, 2, 8, -1, 0, 1'b0, 16'h0);
        join
        drain();
        checks++;
        if (mq_data.size() != 6) begin
            errors++;
            $display("FAIL hold_count: got %0d beats required 6", mq_data.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (mq_tid[i] != etid[i] || mq_data[i] !== pat(etid[i], ebeat[i])) begin
                    errors++;
                    $display("FAIL hold_beat%0d: got tid=%0d required tid=%0d", i, mq_tid[i], etid[i]);
                end
            end
        end
    endtask

    task automatic test_stamp();
        logic [DW-1:0] e0, e1, e2;
        clear_mon();
        m_axis_tready = 1'b1;
        drive_port(1, 2, 48, -1, 0, 1'b1, 16'h0008);
        drive_port(1, 1, 64, -1, 0, 1'b1, 16'hDD86);
        drain();
        e0 = beat_data(1, 48, 1'b1, 16'h0008);
        e1 = beat_data(1, 49, 1'b1, 16'h0008);
        e2 = beat_data(1, 64, 1'b1, 16'hDD86);
`ifdef RMT_TX_STAMP_EN
        e0[42*8 +: 16] = 16'hF0E1;
        e0[44*8 +: 16] = 16'h0002;
`endif
        checks++;
        if (mq_data.size() != 3) begin
            errors++;
            $display("FAIL stamp_count: got %0d beats required 3", mq_data.size());
        end else begin
            checks++;
            if (mq_data[0] !== e0) begin
                errors++;
                $display("FAIL stamp_first: got f42=%h f44=%h required %h %h",
                         mq_data[0][42*8 +: 16], mq_data[0][44*8 +: 16], e0[42*8 +: 16], e0[44*8 +: 16]);
            end
            checks++;
            if (mq_data[1] !== e1) begin
                errors++;
                $display("FAIL stamp_second: got f42=%h required %h", mq_data[1][42*8 +: 16], e1[42*8 +: 16]);
            end
            checks++;
            if (mq_data[2] !== e2) begin
                errors++;
                $display("FAIL stamp_ipv6: got f42=%h required %h", mq_data[2][42*8 +: 16], e2[42*8 +: 16]);
            end
        end
    endtask

    task automatic test_wrap();
        clear_mon();
        m_axis_tready = 1'b1;
        @(negedge clk);
        force dut.cnt_q = 32'hFFFF_FFFF;
        #1 release dut.cnt_q;
        checks++;
        if (stat_frame_count !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL wrap_preload: got %h required ffffffff", stat_frame_count);
        end
        @(posedge clk); #1;
        drive_port(1, 1, 80, -1, 0, 1'b0, 16'h0);
        drain();
        checks++;
        if (stat_frame_count !== 32'd0) begin
            errors++;
            $display("FAIL wrap_count: got %h required 00000000", stat_frame_count);
        end
        checks++;
        if (mq_tid.size() != 1 || mq_tid[0] != 1 || mq_last[0] !== 1'b1) begin
            errors++;
            $display("FAIL wrap_beat: got %0d beats required 1 single-beat frame tid 1", mq_tid.size());
        end
        clear_mon();
        fork
            drive_port(0, 1, 96, -1, 0, 1'b0, 16'h0);
            drive_port(1, 1, 112, -1, 0, 1'b0, 16'h0);
        join
        drain();
        checks++;
        if (mq_tid.size() != 2 || mq_tid[0] != 0 || mq_tid[1] != 1) begin
            errors++;
            $display("FAIL wrap_priority: got %0d beats first tid=%0d required 2 beats first tid=0",
                     mq_tid.size(), (mq_tid.size() > 0) ? mq_tid[0] : -1);
        end
    endtask

    task automatic test_reset_mid();
        bit hs;
        int guard;
        clear_mon();
        m_axis_tready = 1'b1;
        drive_port(0, 1, 128, -1, 0, 1'b0, 16'h0);
        drain();
        td[1] = pat(1, 144); tk[1] = '1; tu[1] = 8'd144; tl[1] = 1'b0; tv[1] = 1'b1;
        hs = 1'b0;
        guard = 0;
        while (!hs && guard < 50) begin
            @(negedge clk);
            hs = s_axis_tready[1];
            @(posedge clk); #1;
            guard++;
        end
        checks++;
        if (!hs) begin
            errors++;
            $display("FAIL rstmid_first: tready=0 required 1 within 50 cycles");
        end
        rst = 1'b1;
        td[1] = pat(1, 145); tu[1] = 8'd145;
        @(negedge clk);
        checks++;
        if (s_axis_tready !== 2'b00) begin
            errors++;
            $display("FAIL rstmid_tready: got %b required 00", s_axis_tready);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        tv[1] = 1'b0;
        @(negedge clk);
        checks++;
        if (m_axis_tvalid !== 1'b0 || m_axis_tid !== 3'd0 || stat_frame_count !== 32'd0) begin
            errors++;
            $display("FAIL rstmid_out: got valid=%b tid=%0d cnt=%0d required 0/0/0",
                     m_axis_tvalid, m_axis_tid, stat_frame_count);
        end
        @(posedge clk); #1;
        clear_mon();
        fork
            drive_port(1, 1, 160, -1, 0, 1'b0, 16'h0);
            drive_port(0, 1, 176, -1, 0, 1'b0, 16'h0);
        join
        drain();
        checks++;
        if (mq_tid.size() != 2) begin
            errors++;
            $display("FAIL rstmid_count: got %0d beats required 2", mq_tid.size());
        end else begin
            checks++;
            if (mq_tid[0] != 0 || mq_data[0] !== pat(0, 176) || mq_tid[1] != 1 || mq_data[1] !== pat(1, 160)) begin
                errors++;
                $display("FAIL rstmid_order: got tids %0d,%0d required 0,1", mq_tid[0], mq_tid[1]);
            end
        end
    endtask

    initial begin
        for (int p = 0; p < SC; p++) begin
            td[p] = '0; tk[p] = '0; tu[p] = '0; tv[p] = 1'b0; tl[p] = 1'b0;
        end
        test_reset();
        test_arbitration();
        test_stall();
        test_hold_grant();
        test_stamp();
        test_wrap();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
